// File: rtl/core_pkg.sv
// Shared core definitions: datapath width and ALU op_select encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package core_pkg;

  localparam int CORE_WORD_LEN = 32;

  typedef enum logic [3:0] {
    ALU_AND = 4'd0,
    ALU_OR  = 4'd1,
    ALU_XOR = 4'd2,
    ALU_ADD = 4'd8,
    ALU_SUB = 4'd9
  } alu_op_t;

endpackage

// File: rtl/regfile.sv
// Architectural register file: 2 async read ports, 1 sync write port, reg 0 reads zero.
// Latency: reads combinational, writes visible the cycle after the write edge.
// Backpressure: none; writes are always accepted.
module regfile
  import core_pkg::*;
#(
  parameter  int WORD_LEN = CORE_WORD_LEN,
  parameter  int NUM_REGS = 32,
  localparam int ADDR_LEN = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_LEN-1:0] i_ra1,
  input  logic [ADDR_LEN-1:0] i_ra2,
  output logic [WORD_LEN-1:0] o_rd1,
  output logic [WORD_LEN-1:0] o_rd2,
  input  logic                i_we,
  input  logic [ADDR_LEN-1:0] i_wa,
  input  logic [WORD_LEN-1:0] i_wd
);

  logic [WORD_LEN-1:0] r_mem [NUM_REGS];

  // Reset clears every register; writes to reg 0 are dropped so it stays zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) r_mem[i] <= '0;
    end else if (i_we && (i_wa != '0)) begin
      r_mem[i_wa] <= i_wd;
    end
  end

  assign o_rd1 = (i_ra1 == '0) ? '0 : r_mem[i_ra1];
  assign o_rd2 = (i_ra2 == '0) ? '0 : r_mem[i_ra2];

endmodule

// File: rtl/operand_issue.sv
// Issue stage: regfile read + writeback forward, busy-scoreboard hazard check, one ALU slot.
// Latency: 1 cycle from accept (in_valid && in_ready) to out_valid.
// Backpressure: in_ready drops on hazard or when the slot is full and out_ready is low.
module operand_issue
  import core_pkg::*;
#(
  parameter  int WORD_LEN = CORE_WORD_LEN,
  parameter  int NUM_REGS = 32,
  localparam int ADDR_LEN = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ADDR_LEN-1:0] in_rs1,
  input  logic [ADDR_LEN-1:0] in_rs2,
  input  logic [ADDR_LEN-1:0] in_rd,
  input  logic                in_we,
  input  logic                in_use_imm,
  input  logic [WORD_LEN-1:0] in_imm,
  input  logic [3:0]          in_op,
  input  logic                wb_valid,
  input  logic [ADDR_LEN-1:0] wb_rd,
  input  logic [WORD_LEN-1:0] wb_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WORD_LEN-1:0] out_a,
  output logic [WORD_LEN-1:0] out_b,
  output logic [3:0]          out_op,
  output logic [ADDR_LEN-1:0] out_rd,
  output logic                out_we
);

  logic [NUM_REGS-1:0] r_busy;
  logic [NUM_REGS-1:0] w_busy_next;
  logic [WORD_LEN-1:0] w_rf_rd1, w_rf_rd2;
  logic [WORD_LEN-1:0] w_rs1_val, w_rs2_val;
  logic                w_fwd1, w_fwd2, w_wb_hits_rd;
  logic                w_hazard, w_issue, w_wb_we;

  assign w_wb_we = wb_valid && (wb_rd != '0);

  regfile #(.WORD_LEN(WORD_LEN), .NUM_REGS(NUM_REGS)) u_regfile (
    .clk   (clk),
    .reset (reset),
    .i_ra1 (in_rs1),
    .i_ra2 (in_rs2),
    .o_rd1 (w_rf_rd1),
    .o_rd2 (w_rf_rd2),
    .i_we  (w_wb_we),
    .i_wa  (wb_rd),
    .i_wd  (wb_data)
  );

  // A writeback landing this cycle is forwarded so the reader need not wait an extra cycle.
  assign w_fwd1       = wb_valid && (wb_rd == in_rs1) && (in_rs1 != '0);
  assign w_fwd2       = wb_valid && (wb_rd == in_rs2) && (in_rs2 != '0);
  assign w_wb_hits_rd = wb_valid && (wb_rd == in_rd);
  assign w_rs1_val    = w_fwd1 ? wb_data : w_rf_rd1;
  assign w_rs2_val    = w_fwd2 ? wb_data : w_rf_rd2;

  // RAW on either live source, or WAW on the destination unless its writeback retires now.
  assign w_hazard = (r_busy[in_rs1] && !w_fwd1)
                  | (!in_use_imm && r_busy[in_rs2] && !w_fwd2)
                  | (in_we && r_busy[in_rd] && !w_wb_hits_rd);

  assign in_ready = !reset && !w_hazard && (!out_valid || out_ready);
  assign w_issue  = in_valid && in_ready;

  // Next scoreboard: clear on writeback first, then set on issue so a new pending write wins.
  always_comb begin
    w_busy_next = r_busy;
    if (w_wb_we) w_busy_next[wb_rd] = 1'b0;
    if (w_issue && in_we && (in_rd != '0)) w_busy_next[in_rd] = 1'b1;
    w_busy_next[0] = 1'b0;
  end

  // Scoreboard register; reset forgets every outstanding write.
  always_ff @(posedge clk) begin
    if (reset) r_busy <= '0;
    else       r_busy <= w_busy_next;
  end

  // ALU slot: load on issue (also when draining), empty on drain, hold while stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_a     <= '0;
      out_b     <= '0;
      out_op    <= '0;
      out_rd    <= '0;
      out_we    <= 1'b0;
    end else if (w_issue) begin
      out_valid <= 1'b1;
      out_a     <= w_rs1_val;
      out_b     <= in_use_imm ? in_imm : w_rs2_val;
      out_op    <= in_op;
      out_rd    <= in_rd;
      out_we    <= in_we;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_operand_issue.sv
// Directed bench for operand_issue: reset, forwarding, stalls, immediates, reg 0 and reset recovery.
// Inputs change 1 time unit after the rising edge; outputs are checked there too.
// Each scenario task does its own comparisons and bumps total/bad.
module tb_operand_issue;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic        in_we, in_use_imm;
  logic [31:0] in_imm;
  logic [3:0]  in_op;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        out_valid, out_ready;
  logic [31:0] out_a, out_b;
  logic [3:0]  out_op;
  logic [4:0]  out_rd;
  logic        out_we;

  int total = 0;
  int bad   = 0;

  operand_issue dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_we(in_we), .in_use_imm(in_use_imm), .in_imm(in_imm), .in_op(in_op),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_op(out_op), .out_rd(out_rd), .out_we(out_we)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                        input logic we, input logic [3:0] op);
    in_valid = 1'b1; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd; in_we = we; in_op = op;
    #1;
  endtask

  task automatic set_wb(input logic v, input logic [4:0] rd, input logic [31:0] d);
    wb_valid = v; wb_rd = rd; wb_data = d;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; in_rs1 = '0; in_rs2 = '0; in_rd = '0; in_we = 1'b0;
    in_use_imm = 1'b0; in_imm = '0; in_op = '0; wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
    out_ready = 1'b1;
    step(); step();
    total++;
    if ({out_valid, out_a, out_b, out_op, out_rd, out_we} !== 75'd0) begin
      bad++; $display("FAIL reset_outputs got v=%b a=%h b=%h op=%h rd=%h we=%b exp all 0",
                      out_valid, out_a, out_b, out_op, out_rd, out_we);
    end
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    reset = 1'b0; #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL post_reset_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_basic_issue();
    set_wb(1'b1, 5'd1, 32'd5); step();
    set_wb(1'b1, 5'd2, 32'd7); step();
    set_wb(1'b0, 5'd0, 32'd0);
    set_op(5'd1, 5'd2, 5'd3, 1'b1, 4'd8);
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL add_ready got=%b exp=1", in_ready); end
    step();
    in_valid = 1'b0; #1;
    total++;
    if ({out_valid, out_a, out_b, out_op, out_rd, out_we} !== {1'b1, 32'd5, 32'd7, 4'd8, 5'd3, 1'b1}) begin
      bad++; $display("FAIL add_slot got v=%b a=%h b=%h op=%h rd=%h we=%b exp v=1 a=5 b=7 op=8 rd=3 we=1",
                      out_valid, out_a, out_b, out_op, out_rd, out_we);
    end
  endtask

  task automatic test_forward();
    set_op(5'd3, 5'd0, 5'd0, 1'b0, 4'd1);
    for (int i = 0; i < 3; i++) begin
      total++;
      if (in_ready !== 1'b0) begin bad++; $display("FAIL raw_stall cycle%0d got=%b exp=0", i, in_ready); end
      step();
    end
    set_wb(1'b1, 5'd3, 32'h12);
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL fwd_ready got=%b exp=1", in_ready); end
    step();
    set_wb(1'b0, 5'd0, 32'd0);
    in_valid = 1'b0; #1;
    total++;
    if ({out_valid, out_a, out_b} !== {1'b1, 32'h12, 32'd0}) begin
      bad++; $display("FAIL fwd_slot got v=%b a=%h b=%h exp v=1 a=12 b=0", out_valid, out_a, out_b);
    end
    set_op(5'd3, 5'd0, 5'd0, 1'b0, 4'd1);
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL busy3_cleared got=%b exp=1", in_ready); end
    in_valid = 1'b0; #1;
  endtask

  task automatic test_stall();
    set_op(5'd1, 5'd2, 5'd5, 1'b1, 4'd9);
    step();
    out_ready = 1'b0;
    set_op(5'd2, 5'd1, 5'd0, 1'b0, 4'd2);
    for (int i = 0; i < 3; i++) begin
      total++;
      if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_ready cycle%0d got=%b exp=0", i, in_ready); end
      step();
      total++;
      if ({out_valid, out_a, out_b, out_op, out_rd} !== {1'b1, 32'd5, 32'd7, 4'd9, 5'd5}) begin
        bad++; $display("FAIL stall_hold cycle%0d got v=%b a=%h b=%h op=%h rd=%h exp v=1 a=5 b=7 op=9 rd=5",
                        i, out_valid, out_a, out_b, out_op, out_rd);
      end
    end
    out_ready = 1'b1; #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL unstall_ready got=%b exp=1", in_ready); end
    step();
    in_valid = 1'b0; #1;
    total++;
    if ({out_valid, out_a, out_b, out_op, out_we} !== {1'b1, 32'd7, 32'd5, 4'd2, 1'b0}) begin
      bad++; $display("FAIL back_to_back got v=%b a=%h b=%h op=%h we=%b exp v=1 a=7 b=5 op=2 we=0",
                      out_valid, out_a, out_b, out_op, out_we);
    end
  endtask

  task automatic test_imm();
    set_op(5'd1, 5'd5, 5'd6, 1'b1, 4'd8);
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL rs2_busy_stall got=%b exp=0", in_ready); end
    in_use_imm = 1'b1; in_imm = 32'hFFFF_FFFF; #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL imm_ready got=%b exp=1", in_ready); end
    step();
    in_valid = 1'b0; in_use_imm = 1'b0; #1;
    total++;
    if ({out_a, out_b} !== {32'd5, 32'hFFFF_FFFF}) begin
      bad++; $display("FAIL imm_slot got a=%h b=%h exp a=5 b=ffffffff", out_a, out_b);
    end
  endtask

  task automatic test_waw();
    set_op(5'd0, 5'd0, 5'd6, 1'b1, 4'd0);
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL waw_stall got=%b exp=0", in_ready); end
    set_wb(1'b1, 5'd6, 32'h33);
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL waw_wb_release got=%b exp=1", in_ready); end
    step();
    set_wb(1'b0, 5'd0, 32'd0);
    set_op(5'd6, 5'd0, 5'd0, 1'b0, 4'd0);
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL set_wins got=%b exp=0", in_ready); end
    in_valid = 1'b0; #1;
  endtask

  task automatic test_reg0();
    set_wb(1'b1, 5'd0, 32'd9);
    set_op(5'd0, 5'd0, 5'd0, 1'b1, 4'd1);
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL r0_ready got=%b exp=1", in_ready); end
    step();
    set_wb(1'b0, 5'd0, 32'd0);
    total++;
    if ({out_a, out_b, out_rd} !== {32'd0, 32'd0, 5'd0}) begin
      bad++; $display("FAIL r0_fwd got a=%h b=%h rd=%h exp 0 0 0", out_a, out_b, out_rd);
    end
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL r0_not_busy got=%b exp=1", in_ready); end
    step();
    in_valid = 1'b0; #1;
    total++;
    if (out_a !== 32'd0) begin bad++; $display("FAIL r0_read got=%h exp=0", out_a); end
  endtask

  task automatic test_reset_mid();
    set_op(5'd1, 5'd2, 5'd4, 1'b1, 4'd8);
    step();
    in_valid = 1'b0;
    reset = 1'b1;
    set_wb(1'b1, 5'd7, 32'hAA);
    set_op(5'd0, 5'd0, 5'd0, 1'b0, 4'd0);
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL mid_reset_ready got=%b exp=0", in_ready); end
    step();
    reset = 1'b0; in_valid = 1'b0;
    set_wb(1'b0, 5'd0, 32'd0);
    total++;
    if ({out_valid, out_a, out_rd, out_we} !== 39'd0) begin
      bad++; $display("FAIL mid_reset_slot got v=%b a=%h rd=%h we=%b exp all 0", out_valid, out_a, out_rd, out_we);
    end
    set_op(5'd4, 5'd1, 5'd4, 1'b1, 4'd8);
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL busy4_cleared got=%b exp=1", in_ready); end
    step();
    set_op(5'd7, 5'd6, 5'd6, 1'b1, 4'd8);
    total++;
    if ({out_a, out_b} !== 64'd0) begin bad++; $display("FAIL regs_cleared got a=%h b=%h exp 0 0", out_a, out_b); end
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL busy6_cleared got=%b exp=1", in_ready); end
    step();
    in_valid = 1'b0; #1;
    total++;
    if ({out_a, out_b} !== 64'd0) begin bad++; $display("FAIL no_partial_wb got a=%h b=%h exp 0 0", out_a, out_b); end
  endtask

  initial begin
    test_reset();
    test_basic_issue();
    test_forward();
    test_stall();
    test_imm();
    test_waw();
    test_reg0();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
